xor_checksum_acc: RTL and testbench
===================================

// Module: xor_checksum_acc
// PURPOSE
//  Multi-lane XOR checksum accumulator: folds LANES x WIDTH-bit words per beat into a
//  running WIDTH-bit XOR over a frame, and presents checksum + parity on frame end.
//  Parametrised sequential successor to the basic 2-input xor gate. Sits on a
//  valid/ready stream as a frame integrity generator/checker.
// PARAMETERS
//  WIDTH  8  bits per lane word and width of checksum
//  LANES  2  words accepted per beat (>=1)
//  CNT_W  8  width of beat counter (saturating)
// PORTS
//  clk        in   1            rising-edge clock, sole clock domain
//  rst        in   1            synchronous, active-high reset
//  in_valid   in   1            input beat valid
//  in_ready   out  1            input beat accepted when in_valid & in_ready
//  in_data    in   LANES*WIDTH  lane i = in_data[i*WIDTH +: WIDTH]
//  in_keep    in   LANES        lane i contributes only if in_keep[i]=1
//  in_last    in   1            final beat of frame
//  out_valid  out  1            checksum result valid
//  out_ready  in   1            result consumed when out_valid & out_ready
//  out_sum    out  WIDTH        XOR of all kept lane words of the frame
//  out_parity out  1            ^out_sum
//  out_beats  out  CNT_W        accepted beats in frame, saturates at 2**CNT_W-1
// BEHAVIOUR
//  - Reset (sync, active-high, one clk edge): state=ACC, acc=0, cnt=0, out_valid=0,
//    out_sum=0, out_parity=0, out_beats=0. in_ready=1 after reset. Reset mid-frame
//    discards partial accumulation; no result is emitted for that frame.
//  - beat_x = XOR over i of (in_keep[i] ? lane_i : 0); acc_nxt = acc ^ beat_x.
//  - States: ACC (no pending result), HOLD (out_valid=1, result waiting).
//  - ACC: in_ready=1. Accepted non-last beat: acc<=acc_nxt, cnt<=sat(cnt+1).
//    Accepted last beat: out_sum<=acc_nxt, out_parity<=^acc_nxt,
//    out_beats<=sat(cnt+1), out_valid<=1, acc<=0, cnt<=0, go HOLD.
//  - Latency: out_valid rises the cycle after the in_last beat is accepted.
//  - HOLD: in_ready = out_ready (combinational; no bubble when consumer is ready).
//    out_ready=0: outputs stable, no input accepted, acc/cnt frozen.
//    out_ready=1, no beat or non-last beat accepted: out_valid<=0, go ACC;
//      beat (if any) accumulates into the next frame as in ACC.
//    out_ready=1 and accepted beat has in_last: new result loaded, out_valid stays 1,
//      remain HOLD (back-to-back single-beat frames at full rate).
//  - out_sum/out_parity/out_beats hold last value after out_valid drops.
//  - Counter saturates, never wraps. in_keep=0 on all lanes still counts as a beat.
//  - Data/keep/last ignored when not accepted. No combinational in->out data path.
// STRUCTURE
//  - Shared include xor_defs.vh: state localparams ST_ACC=1'b0, ST_HOLD=1'b1;
//    default WIDTH/LANES/CNT_W constants.
//  - One sub-module xor_lane_reduce #(WIDTH,LANES): combinational masked XOR of
//    lanes -> beat_x. Top holds FSM, acc, counter, output registers.
// TESTING
//  - Reset then frame 3 beats (LANES=2,keep=11): {01,02},{04,08},{10,20}last ->
//    one cycle later out_valid=1, out_sum=3F, out_parity=0, out_beats=3.
//  - Keep masking: {FF,0F} keep=01 last -> out_sum=0F (lane1 ignored), parity=0.
//  - Backpressure: out_ready=0 for 5 cycles in HOLD -> in_ready=0, out_* stable;
//    then out_ready=1 with beat {AA,00} not last -> out_valid=0 next, acc=AA.
//  - Back-to-back: out_ready=1, single-beat last frames {01,00},{03,00},{07,00} on
//    consecutive cycles -> out_valid continuously 1, out_sum 01,03,07.
//  - Saturation: CNT_W=2, 6-beat frame -> out_beats=3.
//  - Reset mid-frame after 2 beats, then frame {05,00}last -> out_sum=05, beats=1.

Source files
------------

// File: rtl/xor_checksum_acc_pkg.sv
// -----------------------------------------------------------------------------
// xor_checksum_acc_pkg
//   Shared definitions for the XOR checksum accumulator: FSM state encoding
//   and default geometry constants used by the interface and the RTL.
// -----------------------------------------------------------------------------
package xor_checksum_acc_pkg;

   // ACC: no result pending. HOLD: result presented, waiting for consumer.
   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   localparam int DEF_WIDTH = 8;   // bits per lane word and checksum width
   localparam int DEF_LANES = 2;   // lane words accepted per beat
   localparam int DEF_CNT_W = 8;   // width of the saturating beat counter

endpackage : xor_checksum_acc_pkg

// File: rtl/xor_checksum_acc_if.sv
// -----------------------------------------------------------------------------
// xor_checksum_acc_if
//   Bundles the input beat stream and the checksum result stream.
//   Ports (all signals):
//     in_valid/in_ready   input beat handshake
//     in_data             LANES*WIDTH lane words, lane i at [i*WIDTH +: WIDTH]
//     in_keep             per-lane contribute enable
//     in_last             final beat of frame
//     out_valid/out_ready result handshake
//     out_sum/out_parity  frame checksum and its parity
//     out_beats           accepted beats in the frame (saturating)
//   Modports: master drives beats and consumes results; slave is the
//   accumulator.
// -----------------------------------------------------------------------------
interface xor_checksum_acc_if
   import xor_checksum_acc_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int LANES = DEF_LANES,
   parameter int CNT_W = DEF_CNT_W
);

   logic                   in_valid;
   logic                   in_ready;
   logic [LANES*WIDTH-1:0] in_data;
   logic [LANES-1:0]       in_keep;
   logic                   in_last;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH-1:0]       out_sum;
   logic                   out_parity;
   logic [CNT_W-1:0]       out_beats;

   modport master (
      output in_valid, in_data, in_keep, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_parity, out_beats
   );

   modport slave (
      input  in_valid, in_data, in_keep, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_parity, out_beats
   );

endinterface : xor_checksum_acc_if

// File: rtl/xor_checksum_acc_lane_reduce.sv
// -----------------------------------------------------------------------------
// xor_lane_reduce
//   Combinational masked XOR of all lanes of one beat.
//   Ports:
//     i_data   LANES*WIDTH  lane words, lane i at [i*WIDTH +: WIDTH]
//     i_keep   LANES        lane i contributes only when set
//     o_beat_x WIDTH        XOR of the kept lane words (0 when none kept)
// -----------------------------------------------------------------------------
module xor_lane_reduce
   import xor_checksum_acc_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int LANES = DEF_LANES
) (
   input  logic [LANES*WIDTH-1:0] i_data,
   input  logic [LANES-1:0]       i_keep,
   output logic [WIDTH-1:0]       o_beat_x
);

   logic [WIDTH-1:0] w_x;

   always_comb begin
      // NOTE: assign a default before the loop so every path writes w_x;
      // otherwise synthesis infers a latch.
      w_x = '0;
      for (int i = 0; i < LANES; i++) begin
         if (i_keep[i]) begin
            w_x = w_x ^ i_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign o_beat_x = w_x;

endmodule : xor_lane_reduce

// File: rtl/xor_checksum_acc.sv
// -----------------------------------------------------------------------------
// xor_checksum_acc
//   Multi-lane XOR checksum accumulator. Folds the kept lane words of every
//   accepted beat into a running XOR and presents checksum, parity and beat
//   count one cycle after the last beat of a frame is accepted.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset; discards any partial frame
//     bus  xor_checksum_acc_if.slave (input beats + result stream)
// -----------------------------------------------------------------------------
module xor_checksum_acc
   import xor_checksum_acc_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int LANES = DEF_LANES,
   parameter int CNT_W = DEF_CNT_W
) (
   input logic               clk,
   input logic               rst,
   xor_checksum_acc_if.slave bus
);

   state_t           r_state;
   logic [WIDTH-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_parity;
   logic [CNT_W-1:0] r_beats;

   logic [WIDTH-1:0] w_beat_x;
   logic [WIDTH-1:0] w_acc_nxt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_in_ready;
   logic             w_accept;

   xor_lane_reduce #(
      .WIDTH (WIDTH),
      .LANES (LANES)
   ) u_lane_reduce (
      .i_data   (bus.in_data),
      .i_keep   (bus.in_keep),
      .o_beat_x (w_beat_x)
   );

   assign w_acc_nxt = r_acc ^ w_beat_x;
   // Counter sticks at all-ones instead of wrapping.
   assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

   // While a result is pending, a beat may only enter if the result leaves in
   // the same cycle; this keeps back-to-back single-beat frames at full rate.
   assign w_in_ready = (r_state == ST_ACC) || bus.out_ready;
   assign w_accept   = bus.in_valid && w_in_ready;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_ACC;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_sum    <= '0;
         r_parity <= 1'b0;
         r_beats  <= '0;
      end else begin
         case (r_state)
            ST_ACC: begin
               if (w_accept && bus.in_last) begin
                  r_sum    <= w_acc_nxt;
                  r_parity <= ^w_acc_nxt;
                  r_beats  <= w_cnt_inc;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_state  <= ST_HOLD;
               end else if (w_accept) begin
                  r_acc <= w_acc_nxt;
                  r_cnt <= w_cnt_inc;
               end
            end
            ST_HOLD: begin
               // out_ready low: everything frozen (no beat can be accepted).
               if (bus.out_ready) begin
                  if (w_accept && bus.in_last) begin
                     // Result consumed and replaced in the same cycle.
                     r_sum    <= w_acc_nxt;
                     r_parity <= ^w_acc_nxt;
                     r_beats  <= w_cnt_inc;
                     r_acc    <= '0;
                     r_cnt    <= '0;
                  end else begin
                     r_state <= ST_ACC;
                     if (w_accept) begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= w_cnt_inc;
                     end
                  end
               end
            end
            default: r_state <= ST_ACC;
         endcase
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = (r_state == ST_HOLD);
   assign bus.out_sum    = r_sum;
   assign bus.out_parity = r_parity;
   assign bus.out_beats  = r_beats;

endmodule : xor_checksum_acc

// File: tb/tb_xor_checksum_acc.sv
// -----------------------------------------------------------------------------
// tb_xor_checksum_acc
//   Table-driven bench for xor_checksum_acc (LANES=2, WIDTH=8, CNT_W=8) plus a
//   second instance with CNT_W=2 for counter saturation. Each table row is one
//   clock: inputs, expected in_ready before the edge, expected outputs after.
// -----------------------------------------------------------------------------
module tb_xor_checksum_acc;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   xor_checksum_acc_if #(.WIDTH(8), .LANES(2), .CNT_W(8)) bus  ();
   xor_checksum_acc_if #(.WIDTH(8), .LANES(2), .CNT_W(2)) bus2 ();

   xor_checksum_acc #(.WIDTH(8), .LANES(2), .CNT_W(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   xor_checksum_acc #(.WIDTH(8), .LANES(2), .CNT_W(2)) u_dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   typedef struct {
      logic       v;
      logic [7:0] d1;
      logic [7:0] d0;
      logic [1:0] keep;
      logic       last;
      logic       ordy;
      logic       exp_rdy;
      logic       exp_ov;
      logic [7:0] exp_sum;
      logic       exp_par;
      logic [7:0] exp_beats;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic v, input logic [7:0] d1, input logic [7:0] d0,
                      input logic [1:0] keep, input logic last, input logic ordy,
                      input logic exp_rdy, input logic exp_ov, input logic [7:0] exp_sum,
                      input logic exp_par, input logic [7:0] exp_beats);
      vec_t t;
      t = '{v, d1, d0, keep, last, ordy, exp_rdy, exp_ov, exp_sum, exp_par, exp_beats};
      vecs.push_back(t);
   endtask

   // One cycle on the main instance: drive, check in_ready, clock, check outputs.
   task automatic apply(input vec_t t, input string tag);
      @(negedge clk);
      bus.in_valid  = t.v;
      bus.in_data   = {t.d1, t.d0};
      bus.in_keep   = t.keep;
      bus.in_last   = t.last;
      bus.out_ready = t.ordy;
      #1;
      check({tag, " in_ready"}, 32'(bus.in_ready), 32'(t.exp_rdy));
      @(posedge clk);
      #1;
      check({tag, " out_valid"},  32'(bus.out_valid),  32'(t.exp_ov));
      check({tag, " out_sum"},    32'(bus.out_sum),    32'(t.exp_sum));
      check({tag, " out_parity"}, 32'(bus.out_parity), 32'(t.exp_par));
      check({tag, " out_beats"},  32'(bus.out_beats),  32'(t.exp_beats));
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus2.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check({tag, " rst out_valid"},  32'(bus.out_valid),  32'd0);
      check({tag, " rst out_sum"},    32'(bus.out_sum),    32'd0);
      check({tag, " rst out_parity"}, 32'(bus.out_parity), 32'd0);
      check({tag, " rst out_beats"},  32'(bus.out_beats),  32'd0);
      check({tag, " rst in_ready"},   32'(bus.in_ready),   32'd1);
      rst = 1'b0;
   endtask

   initial begin
      vec_t t;

      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.in_keep    = '0;
      bus.in_last    = 1'b0;
      bus.out_ready  = 1'b0;
      bus2.in_valid  = 1'b0;
      bus2.in_data   = '0;
      bus2.in_keep   = '0;
      bus2.in_last   = 1'b0;
      bus2.out_ready = 1'b0;

      // Columns: v d1 d0 keep last ordy | rdy ov sum par beats
      // Three-beat frame, result one cycle after the last beat.
      add(1, 8'h01, 8'h02, 2'b11, 0, 0,  1, 0, 8'h00, 0, 8'd0);
      add(1, 8'h04, 8'h08, 2'b11, 0, 0,  1, 0, 8'h00, 0, 8'd0);
      add(1, 8'h10, 8'h20, 2'b11, 1, 0,  1, 1, 8'h3F, 0, 8'd3);
      add(0, 8'h00, 8'h00, 2'b00, 0, 1,  1, 0, 8'h3F, 0, 8'd3);
      // Keep mask: only lane 0 (0F) contributes.
      add(1, 8'hFF, 8'h0F, 2'b01, 1, 0,  1, 1, 8'h0F, 0, 8'd1);
      // Backpressure: offered last beats must be refused, outputs stable.
      for (int i = 0; i < 5; i++)
         add(1, 8'h55, 8'h33, 2'b11, 1, 0,  0, 1, 8'h0F, 0, 8'd1);
      // Release with a non-last beat: result drops, AA seeds the next frame.
      add(1, 8'hAA, 8'h00, 2'b11, 0, 1,  1, 0, 8'h0F, 0, 8'd1);
      add(1, 8'h00, 8'h01, 2'b11, 1, 1,  1, 1, 8'hAB, 1, 8'd2);
      // Back-to-back single-beat frames, out_valid stays high.
      add(1, 8'h01, 8'h00, 2'b11, 1, 1,  1, 1, 8'h01, 1, 8'd1);
      add(1, 8'h03, 8'h00, 2'b11, 1, 1,  1, 1, 8'h03, 0, 8'd1);
      add(1, 8'h07, 8'h00, 2'b11, 1, 1,  1, 1, 8'h07, 1, 8'd1);
      add(0, 8'h00, 8'h00, 2'b00, 0, 1,  1, 0, 8'h07, 1, 8'd1);
      // All-lanes-masked beat counts; an invalid last beat is ignored.
      add(1, 8'h12, 8'h34, 2'b00, 0, 1,  1, 0, 8'h07, 1, 8'd1);
      add(0, 8'hFF, 8'hFF, 2'b11, 1, 1,  1, 0, 8'h07, 1, 8'd1);
      add(1, 8'h00, 8'h5A, 2'b11, 1, 1,  1, 1, 8'h5A, 0, 8'd2);
      add(0, 8'h00, 8'h00, 2'b00, 0, 1,  1, 0, 8'h5A, 0, 8'd2);

      do_reset("init");

      foreach (vecs[i]) begin
         t = vecs[i];
         apply(t, $sformatf("vec%0d", i));
      end

      // Reset mid-frame: the two partial beats must not leak into the next frame.
      t = '{1, 8'h11, 8'h22, 2'b11, 0, 1, 1, 0, 8'h5A, 0, 8'd2};
      apply(t, "mid0");
      t = '{1, 8'h33, 8'h44, 2'b11, 0, 1, 1, 0, 8'h5A, 0, 8'd2};
      apply(t, "mid1");
      do_reset("mid");
      t = '{1, 8'h00, 8'h05, 2'b11, 1, 0, 1, 1, 8'h05, 0, 8'd1};
      apply(t, "post_rst");

      // Saturation on the CNT_W=2 instance: six beats report 3.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus2.in_valid  = 1'b1;
         bus2.in_data   = {8'h00, 8'(1 << i)};
         bus2.in_keep   = 2'b11;
         bus2.in_last   = (i == 5);
         bus2.out_ready = 1'b0;
         @(posedge clk);
         #1;
         check($sformatf("sat beat%0d out_valid", i), 32'(bus2.out_valid), (i == 5) ? 32'd1 : 32'd0);
      end
      check("sat out_sum",    32'(bus2.out_sum),    32'h3F);
      check("sat out_parity", 32'(bus2.out_parity), 32'd0);
      check("sat out_beats",  32'(bus2.out_beats),  32'd3);
      @(negedge clk);
      bus2.in_valid  = 1'b0;
      bus2.out_ready = 1'b1;
      bus.in_valid   = 1'b0;
      bus.out_ready  = 1'b1;
      @(posedge clk);
      #1;
      check("sat drained out_valid", 32'(bus2.out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_xor_checksum_acc
